// File: rtl/sc_datamem_mmio_if.sv
// Load/store bus between the CPU datapath and the data memory / MMIO block.
interface sc_datamem_mmio_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic        re;
  logic [3:0]  be;
  logic [31:0] dataout;
  logic        rvalid;

  modport master (
    output addr, datain, we, re, be,
    input  dataout, rvalid
  );

  modport slave (
    input  addr, datain, we, re, be,
    output dataout, rvalid
  );
endinterface

// File: rtl/sc_datamem_mmio.sv
// Data memory plus memory-mapped I/O window for the single-cycle CPU.
// Word RAM below the I/O bit, output/input ports, change flags and a
// cycle counter above it. All reads go through one registered port.
module sc_datamem_mmio #(
  parameter int ADDR_W  = 5,
  parameter int IO_BIT  = 7,
  parameter int NUM_OUT = 2,
  parameter int NUM_IN  = 2
) (
  input  logic                  i_clock,
  input  logic                  i_clr,
  sc_datamem_mmio_if.slave      bus,
  input  logic [NUM_IN*32-1:0]  i_in_port,
  output logic [NUM_OUT*32-1:0] o_out_port
);

  localparam int         DEPTH      = 1 << ADDR_W;
  localparam logic [4:0] OFF_CHANGE = 5'd16;
  localparam logic [4:0] OFF_CYCLE  = 5'd17;

  logic [31:0]              r_mem [DEPTH];
  logic [NUM_OUT-1:0][31:0] r_out;
  logic [NUM_IN-1:0][31:0]  r_s1;
  logic [NUM_IN-1:0][31:0]  r_s2;
  logic [NUM_IN-1:0][31:0]  r_s3;
  logic [NUM_IN-1:0]        r_change;
  logic [31:0]              r_cycle;
  logic [31:0]              r_dataout;
  logic                     r_rvalid;

  logic                     w_is_io;
  logic [ADDR_W-1:0]        w_ram_idx;
  logic [4:0]               w_off;
  logic [31:0]              w_mask;
  logic                     w_ram_we;
  logic                     w_io_we;
  logic [31:0]              w_rd_data;
  logic [NUM_IN-1:0]        w_chg_set;
  logic [NUM_IN-1:0]        w_chg_clr;

  assign w_is_io   = bus.addr[IO_BIT];
  assign w_ram_idx = bus.addr[ADDR_W+1:2];
  assign w_off     = bus.addr[6:2];
  assign w_mask    = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
  // Reset wins over stores, including stores to the RAM which is itself never cleared.
  assign w_ram_we  = bus.we & ~w_is_io & ~i_clr;
  assign w_io_we   = bus.we & w_is_io;

  // Byte-masked RAM write; no reset so the array maps onto plain RAM.
  always_ff @(posedge i_clock) begin
    for (int b = 0; b < 4; b++) begin
      if (w_ram_we && bus.be[b]) begin
        r_mem[w_ram_idx][8*b +: 8] <= bus.datain[8*b +: 8];
      end
    end
  end

  // Change detect on the synchronised inputs and W1C clear; flags fit in byte 0.
  always_comb begin
    w_chg_set = '0;
    w_chg_clr = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_chg_set[k] = (r_s2[k] != r_s3[k]);
      w_chg_clr[k] = w_io_we && (w_off == OFF_CHANGE) && bus.be[0] && bus.datain[k];
    end
  end

  // Read mux over RAM and the I/O window; holes and missing ports read 0.
  always_comb begin
    w_rd_data = '0;
    if (!w_is_io) begin
      w_rd_data = r_mem[w_ram_idx];
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_off == 5'(k)) w_rd_data = r_out[k];
      end
      for (int k = 0; k < NUM_IN; k++) begin
        if (w_off == 5'(8 + k)) w_rd_data = r_s2[k];
      end
      if (w_off == OFF_CHANGE) w_rd_data = 32'(r_change);
      if (w_off == OFF_CYCLE)  w_rd_data = r_cycle;
    end
  end

  // Input synchroniser, change flags (set beats clear) and free-running cycle counter.
  always_ff @(posedge i_clock) begin
    if (i_clr) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s3     <= '0;
      r_change <= '0;
      r_cycle  <= '0;
    end else begin
      r_s1     <= i_in_port;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_change <= w_chg_set | (r_change & ~w_chg_clr);
      r_cycle  <= r_cycle + 32'd1;
    end
  end

  // Output port registers with byte-masked writes.
  always_ff @(posedge i_clock) begin
    if (i_clr) begin
      r_out <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_io_we && (w_off == 5'(k))) begin
          r_out[k] <= (r_out[k] & ~w_mask) | (bus.datain & w_mask);
        end
      end
    end
  end

  // Registered read port; sources are sampled before this edge's updates.
  always_ff @(posedge i_clock) begin
    if (i_clr) begin
      r_dataout <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= bus.re;
      if (bus.re) r_dataout <= w_rd_data;
    end
  end

  assign bus.dataout = r_dataout;
  assign bus.rvalid  = r_rvalid;
  assign o_out_port  = r_out;

endmodule

// File: tb/tb_sc_datamem_mmio.sv
// Directed bench for sc_datamem_mmio with an edge-level behavioural model.
module tb_sc_datamem_mmio;

  localparam int ADDR_W  = 4;
  localparam int IO_BIT  = 7;
  localparam int NUM_OUT = 2;
  localparam int NUM_IN  = 2;

  localparam logic [31:0] A_OUT0   = 32'h80;
  localparam logic [31:0] A_OUT1   = 32'h84;
  localparam logic [31:0] A_OUT7   = 32'h9C;
  localparam logic [31:0] A_IN0    = 32'hA0;
  localparam logic [31:0] A_IN1    = 32'hA4;
  localparam logic [31:0] A_IN2    = 32'hA8;
  localparam logic [31:0] A_CHANGE = 32'hC0;
  localparam logic [31:0] A_CYCLE  = 32'hC4;
  localparam logic [31:0] A_HOLE18 = 32'hC8;

  logic        clk;
  logic        clr;
  logic [63:0] in_port;
  logic [63:0] out_port;

  sc_datamem_mmio_if bus ();

  sc_datamem_mmio #(
    .ADDR_W (ADDR_W),
    .IO_BIT (IO_BIT),
    .NUM_OUT(NUM_OUT),
    .NUM_IN (NUM_IN)
  ) dut (
    .i_clock   (clk),
    .i_clr     (clr),
    .bus       (bus),
    .i_in_port (in_port),
    .o_out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [31:0] m_ram [1 << ADDR_W];
  logic [31:0] m_out [NUM_OUT];
  logic [63:0] m_s [3];          // 0: first sync stage, 1: visible value, 2: history
  logic [1:0]  m_chg;
  logic [31:0] m_cyc;
  logic [31:0] exp_dout;
  logic        exp_rv;
  bit          model_valid = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int off;
    off = int'(a[6:2]);
    if (!a[IO_BIT]) return m_ram[(a >> 2) % (1 << ADDR_W)];
    if (off < NUM_OUT) return m_out[off];
    if (off >= 8 && off < 8 + NUM_IN) return m_s[1][(off-8)*32 +: 32];
    if (off == 16) return {30'b0, m_chg};
    if (off == 17) return m_cyc;
    return 32'h0;
  endfunction

  // One clock edge: advance the model with the inputs the DUT sees at that edge.
  task automatic tick();
    logic [31:0] rd;
    logic [31:0] mask;
    int off;
    bit clrb;
    @(posedge clk);
    if (clr) begin
      for (int k = 0; k < NUM_OUT; k++) m_out[k] = '0;
      for (int i = 0; i < 3; i++) m_s[i] = '0;
      m_chg    = '0;
      m_cyc    = '0;
      exp_dout = '0;
      exp_rv   = 1'b0;
    end else begin
      rd   = model_read(bus.addr);
      off  = int'(bus.addr[6:2]);
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (bus.be[b]) mask = mask | (32'hFF << (8*b));
      for (int k = 0; k < NUM_IN; k++) begin
        clrb = bus.we && bus.addr[IO_BIT] && off == 16 && bus.be[0] && bus.datain[k];
        m_chg[k] = (m_s[1][k*32 +: 32] != m_s[2][k*32 +: 32]) || (m_chg[k] && !clrb);
      end
      if (bus.we) begin
        if (!bus.addr[IO_BIT])
          m_ram[(bus.addr >> 2) % (1 << ADDR_W)] =
            (m_ram[(bus.addr >> 2) % (1 << ADDR_W)] & ~mask) | (bus.datain & mask);
        else if (off < NUM_OUT)
          m_out[off] = (m_out[off] & ~mask) | (bus.datain & mask);
      end
      m_s[2] = m_s[1];
      m_s[1] = m_s[0];
      m_s[0] = in_port;
      m_cyc  = m_cyc + 1;
      exp_rv = bus.re;
      if (bus.re) exp_dout = rd;
    end
    model_valid = 1;
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    clr        = c;
    bus.we     = w;
    bus.re     = r;
    bus.addr   = a;
    bus.datain = d;
    bus.be     = b;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b0, 1'b1, 1'b0, a, d, b);
  endtask
  task automatic rd(input logic [31:0] a);
    drive(1'b0, 1'b0, 1'b1, a, 32'h0, 4'h0);
  endtask

  // Every cycle after the first reset: outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("out_port", out_port, {m_out[1], m_out[0]});
      chk("rvalid", 64'(bus.rvalid), 64'(exp_rv));
      chk("dataout", 64'(bus.dataout), 64'(exp_dout));
    end
  end

  initial begin
    clr     = 1'b1;
    in_port = '0;
    bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.datain = '0; bus.be = '0;

    // reset and defaults
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b1, A_OUT0, 32'hFFFF_FFFF, 4'hF);
    chk("rst_out_port", out_port, 64'h0);
    chk("rst_dataout", 64'(bus.dataout), 64'h0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
    rd(A_CYCLE);
    chk("cycle_after_rst", 64'(bus.dataout), 64'h0);
    chk("cycle_rvalid", 64'(bus.rvalid), 64'h1);
    rd(A_CYCLE);
    chk("cycle_second", 64'(bus.dataout), 64'h1);
    idle();
    chk("rvalid_drop", 64'(bus.rvalid), 64'h0);
    chk("dataout_hold", 64'(bus.dataout), 64'h1);

    // RAM byte writes and aliasing
    wr(32'h0C, 32'hAABB_CCDD, 4'hF);
    wr(32'h0C, 32'h1122_3344, 4'h5);
    wr(32'h0C, 32'hFFFF_FFFF, 4'h0);
    rd(32'h0C);
    chk("ram_bytes", 64'(bus.dataout), 64'hAA22_CC44);
    chk("ram_rvalid", 64'(bus.rvalid), 64'h1);
    rd(32'h4C);
    chk("ram_alias", 64'(bus.dataout), 64'hAA22_CC44);

    // output ports and holes
    wr(A_OUT1, 32'h1234_5678, 4'hF);
    chk("out1_write", out_port, 64'h1234_5678_0000_0000);
    wr(A_OUT0, 32'h0000_AB00, 4'h2);
    chk("out0_byte", out_port, 64'h1234_5678_0000_AB00);
    wr(A_OUT7, 32'hFFFF_FFFF, 4'hF);
    chk("out7_ignored", out_port, 64'h1234_5678_0000_AB00);
    rd(A_OUT7);
    chk("out7_reads0", 64'(bus.dataout), 64'h0);
    rd(A_OUT1);
    chk("out1_read", 64'(bus.dataout), 64'h1234_5678);
    rd(A_HOLE18);
    chk("hole18", 64'(bus.dataout), 64'h0);
    rd(A_IN2);
    chk("in2_absent", 64'(bus.dataout), 64'h0);

    // input sync latency and change flag
    in_port = {32'h0, 32'h5};
    idle();
    rd(A_IN0);
    chk("in0_not_yet", 64'(bus.dataout), 64'h0);
    rd(A_IN0);
    chk("in0_edge3", 64'(bus.dataout), 64'h5);
    rd(A_CHANGE);
    chk("change_set", 64'(bus.dataout), 64'h1);
    wr(A_CHANGE, 32'h1, 4'h0);
    rd(A_CHANGE);
    chk("w1c_be_gated", 64'(bus.dataout), 64'h1);
    wr(A_CHANGE, 32'h1, 4'h1);
    rd(A_CHANGE);
    chk("w1c_clear", 64'(bus.dataout), 64'h0);

    // set beats W1C in the same cycle
    in_port = {32'h0, 32'hA};
    idle(); idle(); idle();
    in_port = {32'h0, 32'hB};
    idle(); idle();
    wr(A_CHANGE, 32'h1, 4'h1);
    rd(A_CHANGE);
    chk("set_wins", 64'(bus.dataout), 64'h1);
    wr(A_CHANGE, 32'h3, 4'h1);
    in_port = {32'hCAFE_0001, 32'hB};
    rd(A_CHANGE);
    chk("cleared_again", 64'(bus.dataout), 64'h0);
    idle();
    rd(A_IN1);
    chk("in1_read", 64'(bus.dataout), 64'hCAFE_0001);
    rd(A_CHANGE);
    chk("change_bit1", 64'(bus.dataout), 64'h2);

    // read-before-write and back-to-back reads
    wr(32'h00, 32'h0, 4'hF);
    drive(1'b0, 1'b1, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF);
    chk("rbw_old", 64'(bus.dataout), 64'h0);
    rd(32'h00);
    chk("rbw_new", 64'(bus.dataout), 64'hFFFF_FFFF);
    rd(32'h0C);
    rd(A_OUT1);
    chk("b2b_rvalid", 64'(bus.rvalid), 64'h1);

    // counter wrap
    force dut.r_cycle = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle;
    rd(A_CYCLE);
    chk("cycle_max", 64'(bus.dataout), 64'hFFFF_FFFF);
    rd(A_CYCLE);
    chk("cycle_wrap", 64'(bus.dataout), 64'h0);

    // reset during a read
    rd(A_OUT1);
    drive(1'b1, 1'b0, 1'b1, A_OUT1, 32'h0, 4'h0);
    chk("clr_rvalid", 64'(bus.rvalid), 64'h0);
    chk("clr_dataout", 64'(bus.dataout), 64'h0);
    chk("clr_out_port", out_port, 64'h0);
    rd(32'h0C);
    chk("ram_survives_clr", 64'(bus.dataout), 64'hAA22_CC44);
    idle();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
